sram_bus_ctrl: RTL and testbench

Request-side controller that sits directly upstream of the 64x8 single-port StaticRAM and owns its bus (`ce`, `rw`, `addr`, bidirectional `data`). It accepts single-beat write and burst read requests over a valid/ready handshake and sequences the RAM bus cycle by cycle. It inserts a turnaround cycle after reads so the controller and RAM never drive the shared data bus together, and it returns read data as a one-beat-per-cycle response stream.

---
 rtl/sram_bus_ctrl.sv | 109 ++++++++++
 tb/tb_sram_bus_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_ctrl.sv
// Bus controller for a single-port SRAM: single-beat writes, burst reads with a
// turnaround cycle, and a fixed-latency capture pipeline for read data.
module sram_bus_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [ADDR_W-1:0] i_req_len,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_last,
  output logic              o_ce,
  output logic              o_rw,
  output logic [ADDR_W-1:0] o_addr,
  inout  wire  [DATA_W-1:0] io_data
);

  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, WRITE, READ, TURN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state, nxt;
  req_t              req_q;
  logic              accept, rd_issue, rd_last, drive;
  logic [STAGES:1]   vld_pipe, last_pipe;

  assign accept   = i_req_valid && o_req_ready;
  assign rd_issue = (state == READ);
  assign rd_last  = rd_issue && (req_q.cnt == '0);

  always_comb begin
    nxt         = state;
    o_ce        = 1'b0;
    o_rw        = 1'b1;
    drive       = 1'b0;
    o_req_ready = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = !i_rst;
        if (accept) nxt = i_req_wr ? WRITE : READ;
      end
      WRITE: begin
        o_ce        = 1'b1;
        o_rw        = 1'b0;
        drive       = 1'b1;
        o_req_ready = !i_rst;
        if (accept) nxt = i_req_wr ? WRITE : READ;
        else        nxt = IDLE;
      end
      READ: begin
        o_ce = 1'b1;
        if (rd_last) nxt = TURN;
      end
      TURN:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= nxt;
  end

  // cnt counts remaining read beats; addr doubles as the burst address counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_q <= '0;
    end else if (accept) begin
      req_q.addr  <= i_req_addr;
      req_q.cnt   <= i_req_wr ? '0 : i_req_len;
      req_q.wdata <= i_req_wdata;
    end else if (rd_issue && !rd_last) begin
      req_q.addr <= req_q.addr + 1'b1;
      req_q.cnt  <= req_q.cnt - 1'b1;
    end
  end

  assign o_addr  = req_q.addr;
  assign io_data = drive ? req_q.wdata : 'z;

  // Stage 1 covers the cycle the RAM drives the bus; stage 2 holds the captured beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      o_rsp_data <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], rd_issue};
      last_pipe <= {last_pipe[STAGES-1:1], rd_last};
      if (vld_pipe[1]) o_rsp_data <= io_data;
    end
  end

  assign o_rsp_valid = vld_pipe[STAGES];
  assign o_rsp_last  = last_pipe[STAGES];

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Bench for sram_bus_ctrl: behavioural 64x8 RAM on the shared bus, read-response
// scoreboard, directed write/read/wrap/turnaround/reset sequences.
`define CHK(tag, obs, exp) begin compared++; assert ((obs) === (exp)) else begin mismatched++; $error("FAIL %s: got %0h, expected %0h", tag, (obs), (exp)); end end

module tb_sram_bus_ctrl;
  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_len = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          ce, rw;
  logic [AW-1:0] addr;
  wire  [DW-1:0] data_bus;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int last_rsp_cyc = 0;
  int conflicts = 0;

  logic [DW-1:0] mem [64];
  logic [DW-1:0] exp_mem [64];
  logic          ram_drive = 1'b0;
  logic [AW-1:0] ram_addr = '0;
  logic [DW:0]   sbq [$];
  logic [DW:0]   sb_e;

  sram_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wr(req_wr),
    .i_req_addr(req_addr), .i_req_len(req_len), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_last(rsp_last),
    .o_ce(ce), .o_rw(rw), .o_addr(addr), .io_data(data_bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: captures writes at the edge, drives read data the following cycle
  assign data_bus = ram_drive ? mem[ram_addr] : 'z;
  always @(posedge clk) begin
    if (ce && !rw && ram_drive) conflicts <= conflicts + 1;
    ram_drive <= ce && rw;
    ram_addr  <= addr;
    if (ce && !rw) mem[addr] <= data_bus;
  end

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_rsp_cyc = cyc + 1;
      compared++;
      assert (sbq.size() > 0) else begin
        mismatched++;
        $error("FAIL rsp_unexpected: got data %0h, expected no response", rsp_data);
      end
      if (sbq.size() > 0) begin
        sb_e = sbq.pop_front();
        `CHK("rsp_last_data", {rsp_last, rsp_data}, sb_e)
      end
    end
  end

  task automatic send(input bit wr, input int a, input int len, input int d, output int acc);
    int n;
    logic [AW-1:0] idx;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = AW'(a);
    req_len   = AW'(len);
    req_wdata = DW'(d);
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    compared++;
    assert (n < 200) else begin
      mismatched++;
      $error("FAIL req_timeout: waited %0d cycles, expected fewer than 200", n);
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b0;
    if (wr) begin
      exp_mem[AW'(a)] = DW'(d);
    end else begin
      for (int j = 0; j <= len; j++) begin
        idx = AW'(a) + AW'(j);
        sbq.push_back({(j == len), exp_mem[idx]});
      end
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    `CHK(tag, int'(sbq.size()), 0)
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int acc_w, acc_r, base, n;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end

    // asynchronous reset asserted mid-cycle, before any clock edge
    #3 rst = 1'b1;
    #1;
    `CHK("rst_ce", ce, 1'b0)
    `CHK("rst_rw", rw, 1'b1)
    `CHK("rst_addr", addr, 6'd0)
    `CHK("rst_rsp_valid", rsp_valid, 1'b0)
    `CHK("rst_rsp_data", rsp_data, 8'h00)
    `CHK("rst_rsp_last", rsp_last, 1'b0)
    `CHK("rst_bus_z", data_bus, 8'hzz)
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    `CHK("rst_ready", req_ready, 1'b1)

    // single write then single-beat read
    send(1'b1, 5, 0, 8'hA5, acc_w);
    base = rsp_cnt;
    send(1'b0, 5, 0, 0, acc_r);
    @(negedge clk);
    `CHK("single_early_valid", rsp_valid, 1'b0)
    drain("single_drain");
    `CHK("single_latency", last_rsp_cyc - acc_r, 3)
    `CHK("single_count", rsp_cnt - base, 1)

    // fill all 64 words back to back, then dump in one burst
    for (int i = 0; i < 64; i++) begin
      send(1'b1, i, 0, i + 1, acc_w);
      `CHK("fill_ce_rw", {ce, rw}, 2'b10)
    end
    base = rsp_cnt;
    send(1'b0, 0, 63, 0, acc_r);
    drain("dump_drain");
    `CHK("dump_count", rsp_cnt - base, 64)

    // address wrap from 63 to 0
    send(1'b0, 62, 3, 0, acc_r);
    `CHK("wrap_addr0", addr, 6'd62)
    @(negedge clk);
    `CHK("wrap_addr1", addr, 6'd63)
    @(negedge clk);
    `CHK("wrap_addr2", addr, 6'd0)
    @(negedge clk);
    `CHK("wrap_addr3", addr, 6'd1)
    @(negedge clk);
    `CHK("wrap_turn_ce", ce, 1'b0)
    drain("wrap_drain");

    // write held pending across a read burst; accepted only after TURN
    send(1'b0, 10, 7, 0, acc_r);
    send(1'b1, 20, 0, 8'h5C, acc_w);
    `CHK("turn_accept_gap", acc_w - acc_r, 10)
    send(1'b0, 20, 0, 0, acc_r);
    drain("turn_drain");
    `CHK("bus_conflicts", conflicts, 0)

    // reset during beat 10 of a 32-beat read
    base = rsp_cnt;
    send(1'b0, 0, 31, 0, acc_r);
    n = 0;
    while (rsp_cnt - base < 10 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    `CHK("midrst_beats_seen", rsp_cnt - base, 10)
    rst = 1'b1;
    #1;
    `CHK("midrst_rsp_valid", rsp_valid, 1'b0)
    `CHK("midrst_ce", ce, 1'b0)
    `CHK("midrst_rw", rw, 1'b1)
    `CHK("midrst_addr", addr, 6'd0)
    `CHK("midrst_rsp_data", rsp_data, 8'h00)
    sbq.delete();
    base = rsp_cnt;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    `CHK("midrst_ready", req_ready, 1'b1)
    repeat (8) @(negedge clk);
    `CHK("midrst_no_rsp", rsp_cnt - base, 0)
    send(1'b0, 0, 0, 0, acc_r);
    drain("post_rst_drain");
    `CHK("post_rst_count", rsp_cnt - base, 1)

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
